uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Receive-path controller of the UART RX, directly upstream of the parity checker and sibling of the start-bit/stop-bit checkers, data sampler and deserializer.
- Detects the start bit, sequences START/DATA/PARITY/STOP bit periods on the oversampling clock, and owns the edge and bit counters.
- Issues one-cycle check and shift enables to the neighbouring stages, and qualifies the frame with data_valid from the returned error flags.

Parameters:
- DATA_WIDTH, 8, data bits per frame (LSB first).
- PRESC_W, 6, width of prescale and edge_cnt (supports prescale up to 32).

Ports:
- clk  in  1  oversampling clock (one cycle = one oversample tick).
- rst  in  1  reset; synchronous, active-high.
- rx_in  in  1  serial line, idle high.
- par_en  in  1  frame carries a parity bit.
- prescale  in  PRESC_W  oversample ratio; legal values are 8, 16 and 32.
- par_err  in  1  registered flag from the parity checker.
- strt_glitch  in  1  registered flag from the start checker.
- stp_err  in  1  registered flag from the stop checker.
- dat_samp_en  out  1  data sampler enable.
- edge_cnt  out  PRESC_W  current tick within the bit, 0..prescale-1.
- bit_cnt  out  4  data bit index, 0..DATA_WIDTH-1.
- strt_chk_en  out  1  one-cycle start check strobe.
- deser_en  out  1  one-cycle deserializer shift strobe.
- par_chk_en  out  1  one-cycle parity check strobe.
- stp_chk_en  out  1  one-cycle stop check strobe.
- data_valid  out  1  one-cycle frame-good pulse.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; edge_cnt=0; bit_cnt=0; all strobes and data_valid=0; dat_samp_en=0. Reset mid-frame aborts the frame with no data_valid.
- Frame capture: prescale and par_en are captured on IDLE->START and held for the whole frame. A non-legal prescale is captured as 8.
- Let P = captured prescale, H = P/2, SAMP = H+2, LAST = P-1. The sampler votes at ticks H-1, H and H+1; its output is stable from tick SAMP.
- edge_cnt: increments every cycle in non-IDLE states and wraps LAST->0. It is held at 0 in IDLE. Every bit period is exactly P cycles.
- dat_samp_en = 1 in all non-IDLE states.
- IDLE: when rx_in=0, next state is START with edge_cnt=0.
- START: strt_chk_en=1 when edge_cnt==SAMP. At LAST: if strt_glitch=1, go to IDLE with no further strobes; otherwise go to DATA with bit_cnt=0.
- DATA: deser_en=1 when edge_cnt==SAMP. At LAST:
  - if bit_cnt==DATA_WIDTH-1, go to PARITY if par_en, else STOP;
  - otherwise bit_cnt++.
- PARITY: par_chk_en=1 when edge_cnt==SAMP. At LAST, go to STOP; a parity error does not abort the frame.
- STOP: stp_chk_en=1 when edge_cnt==SAMP. At LAST, go to IDLE, and data_valid=1 on the next cycle iff stp_err==0 and (par_en==0 or par_err==0).
- Checker flags are registered one cycle after their strobe, so they are stable at LAST.
- Latency: with the first START cycle as t=0, data_valid is high in cycle N*P only, where N = 1 + DATA_WIDTH + par_en + 1.
- Back-to-back frames: IDLE is re-entered at cycle N*P. A low rx_in in that cycle starts the next frame, giving a one-tick gap.
- bit_cnt holds its value outside DATA and is cleared on START->DATA.
- All strobes are mutually exclusive and last exactly one cycle per bit.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - constants PRESC_8/16/32 and default DATA_WIDTH;
  - helper function for SAMP/LAST.
- One sub-module, uart_edge_bit_counter, owns edge_cnt and bit_cnt with run/clear/bit_inc controls. The FSM stays in uart_rx_fsm.

Test Plan:
- Good frame, prescale=8, par_en=1, byte 0xA5, even parity, par_err=0, stp_err=0 -> deser_en pulses at cycles 14, 22 … 70; par_chk_en at 78; stp_chk_en at 86; data_valid high only at cycle 88.
- Glitch: rx_in low for 2 ticks only, strt_glitch=1 at tick 7 -> return to IDLE at cycle 8; no deser_en and no data_valid.
- Parity error: as the good frame but par_err=1 after cycle 79 -> full sequence runs, data_valid stays 0, FSM back in IDLE at 88.
- No parity, prescale=16, stp_err=1 -> STOP follows bit 7 and stp_chk_en fires at cycle 154; data_valid=0. Repeating with stp_err=0 gives data_valid at cycle 160.
- Reset mid-frame: rst=1 at cycle 40 of a prescale=8 frame -> next cycle state=IDLE, edge_cnt=0, bit_cnt=0, all outputs 0, no data_valid.
- Back-to-back frames plus illegal prescale=12 -> treated as 8; the second start is detected at cycle 88 and the second data_valid appears at cycle 177.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and timing helpers for the UART receive-path controller.
// Tick positions are derived from the oversample ratio captured at frame start.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PRESC_8        = 8;
  localparam int PRESC_16       = 16;
  localparam int PRESC_32       = 32;
  localparam int DEF_DATA_WIDTH = 8;

  // Sampler votes at H-1..H+1, so its output is settled two ticks after mid-bit.
  function automatic int samp_tick(input int p);
    return p / 2 + 2;
  endfunction

  function automatic int last_tick(input int p);
    return p - 1;
  endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample tick counter and data bit index for the UART receiver.
// The edge counter runs only while a frame is in progress and otherwise sits at 0.
module uart_edge_bit_counter #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [PRESC_W-1:0] last_val,
  input  logic               bit_clr,
  input  logic               bit_inc,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               at_last
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;

  assign at_last = (edge_cnt_q == last_val);

  always_comb begin
    edge_cnt_d = '0;
    if (run) begin
      edge_cnt_d = at_last ? '0 : edge_cnt_q + PRESC_W'(1);
    end

    bit_cnt_d = bit_cnt_q;
    if (bit_clr) begin
      bit_cnt_d = '0;
    end else if (bit_inc) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive-path sequencer: walks START/DATA/PARITY/STOP bit periods and
// strobes the neighbouring checkers, then qualifies the frame with data_valid.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_err,
  input  logic               strt_glitch,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
);

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic               par_en_q, par_en_d;
  logic               data_valid_q, data_valid_d;
  logic [PRESC_W-1:0] samp_val, last_val;
  logic               run, bit_clr, bit_inc, at_last;
  logic               samp_hit, last_bit, prescale_legal;

  assign prescale_legal = (prescale == PRESC_W'(PRESC_8))  ||
                          (prescale == PRESC_W'(PRESC_16)) ||
                          (prescale == PRESC_W'(PRESC_32));

  assign samp_val = PRESC_W'(samp_tick(int'(prescale_q)));
  assign last_val = PRESC_W'(last_tick(int'(prescale_q)));
  assign samp_hit = (edge_cnt == samp_val);
  assign last_bit = (bit_cnt == 4'(DATA_WIDTH - 1));

  uart_edge_bit_counter #(
    .PRESC_W (PRESC_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .last_val (last_val),
    .bit_clr  (bit_clr),
    .bit_inc  (bit_inc),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .at_last  (at_last)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    data_valid_d = 1'b0;
    run          = 1'b0;
    bit_clr      = 1'b0;
    bit_inc      = 1'b0;
    strt_chk_en  = 1'b0;
    deser_en     = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    dat_samp_en  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d    = START;
          prescale_d = prescale_legal ? prescale : PRESC_W'(PRESC_8);
          par_en_d   = par_en;
        end
      end
      START: begin
        run         = 1'b1;
        strt_chk_en = samp_hit;
        if (at_last) begin
          if (strt_glitch) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_clr = 1'b1;
          end
        end
      end
      DATA: begin
        run      = 1'b1;
        deser_en = samp_hit;
        if (at_last) begin
          if (last_bit) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        run        = 1'b1;
        par_chk_en = samp_hit;
        if (at_last) begin
          state_d = STOP;
        end
      end
      STOP: begin
        run        = 1'b1;
        stp_chk_en = samp_hit;
        // Checker flags were registered right after their strobes, so they are settled here.
        if (at_last) begin
          state_d      = IDLE;
          data_valid_d = !stp_err && (!par_en_q || !par_err);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prescale_q   <= PRESC_W'(PRESC_8);
      par_en_q     <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: each frame pushes its expected strobe/valid
// events with absolute cycle numbers, and every cycle's outputs are matched against them.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       par_err;
  logic       strt_glitch;
  logic       stp_err;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t sb[$];

  uart_rx_fsm #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .par_err     (par_err),
    .strt_glitch (strt_glitch),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d, required completion earlier", cyc);
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      0:       return "strt_chk_en";
      1:       return "deser_en";
      2:       return "par_chk_en";
      3:       return "stp_chk_en";
      default: return "data_valid";
    endcase
  endfunction

  // Advance one cycle, matching any outputs seen mid-cycle against the scoreboard.
  task automatic step();
    logic [4:0] s;
    ev_t        e;
    @(negedge clk);
    s = {data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
    checks++;
    if ($countones(s) > 1) begin
      errors++;
      $display("FAIL strobe_exclusive cycle %0d got %b required at most one bit set", cyc, s);
    end
    for (int k = 0; k < 5; k++) begin
      if (s[k]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %s at cycle %0d required none", kname(k), cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || e.at != cyc) begin
            errors++;
            $display("FAIL event_order got %s at cycle %0d required %s at cycle %0d",
                     kname(k), cyc, kname(e.kind), e.at);
          end else begin
            $display("event %s at cycle %0d ok", kname(k), cyc);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; t0 is the cycle whose START tick is edge_cnt==0.
  task automatic send_frame(input logic [5:0] presc_in, input int p, input bit pe,
                            input logic [7:0] data, input bit glitch, input bit par_bad,
                            input bit stp_bad, input int rst_at, output int t0);
    int          samp;
    int          nb;
    int          len;
    int          rel;
    bit          exp_dv;
    logic [11:0] line;
    ev_t         ev;
    samp   = p / 2 + 2;
    nb     = pe ? 11 : 10;
    line   = pe ? {2'b11, ^data, data, 1'b0} : {3'b111, data, 1'b0};
    exp_dv = !glitch && (rst_at < 0) && !stp_bad && !(pe && par_bad);
    len    = glitch ? p : ((rst_at >= 0) ? rst_at + 1 : nb * p);

    prescale    = presc_in;
    par_en      = pe;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    rx_in       = 1'b0;
    step();
    t0 = cyc;

    for (int b = 0; b < nb; b++) begin
      rel     = b * p + samp;
      ev.kind = (b == 0) ? 0 : (b <= 8) ? 1 : (pe && b == 9) ? 2 : 3;
      ev.at   = t0 + rel;
      if ((!glitch || b == 0) && (rst_at < 0 || rel <= rst_at)) sb.push_back(ev);
    end
    if (exp_dv) begin
      ev.kind = 4;
      ev.at   = t0 + nb * p;
      sb.push_back(ev);
    end
    $display("frame presc=%0d pe=%0d data=%02h glitch=%0d par_bad=%0d stp_bad=%0d rst_at=%0d t0=%0d",
             presc_in, pe, data, glitch, par_bad, stp_bad, rst_at, t0);

    for (int t = 0; t < len; t++) begin
      if (t > 0 && (t % p) == 0) line = line >> 1;
      rx_in = glitch ? (t == 0 ? 1'b0 : 1'b1) : line[0];
      if (t == samp + 1) strt_glitch = glitch;
      if (pe && t == 9 * p + samp + 1) par_err = par_bad;
      if (t == (nb - 1) * p + samp + 1) stp_err = stp_bad;
      rst = (t == rst_at);
      step();
    end
    rst   = 1'b0;
    rx_in = 1'b1;

    checks++;
    if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_frame got samp_en=%b edge=%0d required 0/0", dat_samp_en, edge_cnt);
    end
    checks++;
    if (data_valid !== exp_dv) begin
      errors++;
      $display("FAIL data_valid_level got %b required %b at cycle %0d", data_valid, exp_dv, cyc);
    end
    if (!glitch) begin
      checks++;
      if (bit_cnt !== ((rst_at >= 0) ? 4'd0 : 4'd7)) begin
        errors++;
        $display("FAIL bit_cnt_after_frame got %0d required %0d", bit_cnt, (rst_at >= 0) ? 0 : 7);
      end
    end
  endtask

  task automatic drain();
    repeat (4) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d left, next %s at cycle %0d, required 0",
               sb.size(), kname(sb[0].kind), sb[0].at);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b0; par_en = 1'b1; prescale = 6'd8;
    par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid} !== 6'b0 ||
        edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got en=%b edge=%0d bit=%0d required all zero",
               {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid},
               edge_cnt, bit_cnt);
    end
    rst = 1'b0; rx_in = 1'b1;
    step();
    step();
    checks++;
    if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
      errors++;
      $display("FAIL idle_hold got samp_en=%b edge=%0d required 0/0", dat_samp_en, edge_cnt);
    end
  endtask

  task automatic test_good_frame();
    int t0;
    send_frame(6'd8, 8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, -1, t0);
    drain();
  endtask

  task automatic test_glitch();
    int t0;
    send_frame(6'd8, 8, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, -1, t0);
    drain();
  endtask

  task automatic test_parity_error();
    int t0;
    send_frame(6'd8, 8, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, -1, t0);
    drain();
  endtask

  task automatic test_no_parity_p16();
    int t0;
    send_frame(6'd16, 16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, t0);
    drain();
    send_frame(6'd16, 16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, t0);
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    send_frame(6'd8, 8, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 40, t0);
    checks++;
    if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_strobes got %b required 00000",
               {strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t0a;
    int t0b;
    send_frame(6'd12, 8, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, -1, t0a);
    send_frame(6'd12, 8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, -1, t0b);
    drain();
  endtask

  task automatic test_prescale_32();
    int t0;
    send_frame(6'd32, 32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, -1, t0);
    drain();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_parity_error();
    test_no_parity_p16();
    test_reset_mid_frame();
    test_back_to_back();
    test_prescale_32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
